// File: rtl/cla_seq_ctrl.sv
// Two-requester add controller that time-shares one 4-bit carry-lookahead slice
// across NIBBLES slices per operation, with round-robin arbitration and a held result.

module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g, p;
    logic       c1, c2, c3;

    assign g = a & b;
    assign p = a | b;

    // Fully expanded lookahead so every carry is a flat function of g, p and ci.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s  = a ^ b ^ {c3, c2, c1, ci};
endmodule

module cla_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic                 req0_ci,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    input  logic                 req1_ci,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [4*NIBBLES-1:0] rsp_sum,
    output logic                 rsp_co,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   a_q, b_q;
    logic           carry_q;
    logic [KW-1:0]  k_q;
    logic           last_q;
    logic           gnt, accept;
    logic [KW+1:0]  sh;
    logic [W-1:0]   a_sh, b_sh, nib_mask, nib_ins;
    logic [3:0]     slice_s;
    logic           slice_co;

    // gnt is the requester index that would win this cycle; ties go away from last_q.
    always_comb begin
        gnt = req1_valid;
        if (req0_valid && req1_valid) gnt = ~last_q;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !gnt;
    assign req1_ready = (state == IDLE) && req1_valid && gnt;
    assign accept     = req0_ready | req1_ready;

    assign sh       = {k_q, 2'b00};
    assign a_sh     = a_q >> sh;
    assign b_sh     = b_q >> sh;
    assign nib_mask = W'(4'hF) << sh;
    assign nib_ins  = W'(slice_s) << sh;

    cla4 u_slice (
        .a  (a_sh[3:0]),
        .b  (b_sh[3:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ADD;
            ADD:     if (k_q == KW'(NIBBLES - 1)) state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            last_q  <= 1'b1;
            rsp_id  <= 1'b0;
            rsp_sum <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (accept) begin
                    a_q     <= gnt ? req1_a  : req0_a;
                    b_q     <= gnt ? req1_b  : req0_b;
                    carry_q <= gnt ? req1_ci : req0_ci;
                    rsp_id  <= gnt;
                    k_q     <= '0;
                end
                ADD: begin
                    rsp_sum <= (rsp_sum & ~nib_mask) | nib_ins;
                    carry_q <= slice_co;
                    k_q     <= k_q + 1'b1;
                end
                DONE: if (rsp_ready) last_q <= rsp_id;
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_co    = carry_q;
    assign busy      = (state != IDLE);
endmodule

// File: doc/cla_seq_ctrl.md
CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, SHALL set the number of 4-bit slices per operation; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  SHALL each indicate that requester 0 or 1 presents an add operation.
REQ-005 req0_ready / req1_ready  output  1  SHALL each indicate that the controller accepts requester 0 or 1 this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  W  SHALL be the operands.
REQ-007 req0_ci / req1_ci  input  1  SHALL be the carry-in.
REQ-008 rsp_valid  output  1  SHALL indicate that the result is valid.
REQ-009 rsp_ready  input  1  SHALL indicate that the result consumer accepts.
REQ-010 rsp_id  output  1  SHALL give the index of the requester that owns the result.
REQ-011 rsp_sum  output  W  SHALL carry the sum.
REQ-012 rsp_co  output  1  SHALL carry the final carry-out.
REQ-013 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-014 The block SHALL contain exactly one 4-bit carry-lookahead slice (g=a&b, p=a|b, c[i+1]=g[i]|p[i]&c[i], s[i]=a[i]^b[i]^c[i]), time-shared across nibbles and requesters.
REQ-015 The FSM SHALL have states IDLE, ADD and DONE and SHALL enter IDLE on reset.
REQ-016 In IDLE, the grant SHALL go to the single valid requester; if both are valid, it SHALL go to the requester not granted last (round-robin).
REQ-017 reqN_ready SHALL be high only in IDLE and only for the granted requester, combinationally from the valids and the last-grant pointer; the ready of the other requester SHALL be low.
REQ-018 On reqN_valid&reqN_ready, the block SHALL latch a, b and ci; set rsp_id=N; clear the nibble index to 0; and go to ADD.
REQ-019 Each ADD cycle k (0..NIBBLES-1) SHALL feed nibble k of a, b and the carry register to the slice, write the slice sum to rsp_sum[4k+3:4k], load the carry register with the slice c4, and increment k.
REQ-020 After nibble NIBBLES-1, the FSM SHALL go to DONE.
REQ-021 In DONE, rsp_valid=1, rsp_co equals the carry register, and rsp_sum, rsp_co and rsp_id SHALL stay stable until rsp_ready.
REQ-022 On rsp_valid&rsp_ready, the FSM SHALL go to IDLE and update the last-grant pointer to rsp_id.
REQ-023 Latency SHALL be exactly NIBBLES+1 clocks from the accept edge to the first cycle with rsp_valid=1.
REQ-024 Peak throughput SHALL be one operation per NIBBLES+2 clocks.
REQ-025 Arithmetic SHALL be modulo 2^W with carry-out in rsp_co; {rsp_co,rsp_sum} SHALL equal a+b+ci exactly.
REQ-026 Requester inputs outside the accept cycle SHALL be ignored; changes to a, b or ci during ADD SHALL not affect the result.
REQ-027 A requester that deasserts valid before being granted SHALL lose nothing; no request SHALL be queued.
REQ-028 rsp_sum SHALL not be required to hold a meaningful value outside DONE, but SHALL not be X after reset.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously force state=IDLE, rsp_valid=0, busy=0, rsp_sum=0, rsp_co=0, rsp_id=0, the carry register=0, the nibble index=0 and the last-grant pointer=1, so that requester 0 wins the first tie.
REQ-030 Reset during ADD or DONE SHALL discard the in-flight operation, and no rsp_valid SHALL follow it.
REQ-031 Deassertion of reset SHALL take effect at the next rising clk edge, with no spurious ready or valid.

Verification
REQ-032 Bench SHALL drive req0 a=0x0009, b=0x0001, ci=0 -> rsp_sum=0x000A, rsp_co=0, rsp_id=0, rsp_valid at the accept edge+5 clocks.
REQ-033 Bench SHALL drive req1 a=0xFFFF, b=0x0001, ci=0 -> rsp_sum=0x0000, rsp_co=1 (carry ripples through all nibbles); then a=0x7FFF, b=0x0000, ci=1 -> 0x8000, co=0.
REQ-034 Bench SHALL assert both valids after reset with req0 0x1234+0x1111 and req1 0xF000+0x1000 -> first result id=0, sum=0x2345; next id=1, sum=0x0000, co=1; both valids held again -> req0 wins next (alternation).
REQ-035 Bench SHALL hold rsp_ready=0 for 3 cycles in DONE -> rsp_valid, sum, co and id stable throughout, both readys low, busy=1; accept on the 4th cycle -> IDLE next cycle.
REQ-036 Bench SHALL pulse rst_n low mid-ADD (k=2) -> busy=0 and rsp_valid=0 immediately; no response for the aborted op; the next request completes correctly.
REQ-037 Bench SHALL check 1000 random operands and ci against a+b+ci, together with random rsp_ready stalls and random valids.
